// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and compare-operand stalls, control-flow flushes,
// whole-pipe freeze on data-memory wait states, plus stall statistics and a memory timeout flag.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             ifid_uses_rt,
   input  logic [2:0]       ifid_pcsrc,
   input  logic             branch_taken,
   input  logic [4:0]       idex_rd,
   input  logic             idex_regwr,
   input  logic             idex_memrd,
   input  logic [4:0]       exmem_rd,
   input  logic             exmem_regwr,
   input  logic             exmem_memrd,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_wr,
   output logic             ifid_wr,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             pipe_hold,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             mem_err
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   state_t          state;
   logic [WC_W-1:0] wait_cnt;

   logic ex_match, mem_match, is_cmp;
   logic lu, br_ex, br_mem, hz;
   logic freeze, redirect;

   // The compare path only stalls on MEM-stage loads, so the MEM write flag carries no extra information.
   logic unused_inputs;
   assign unused_inputs = exmem_regwr;

   assign ex_match  = (idex_rd != 5'd0) &&
                      ((idex_rd == ifid_rs) || (ifid_uses_rt && (idex_rd == ifid_rt)));
   assign mem_match = (exmem_rd != 5'd0) &&
                      ((exmem_rd == ifid_rs) || (ifid_uses_rt && (exmem_rd == ifid_rt)));
   assign is_cmp    = (ifid_pcsrc == 3'b001) || (ifid_pcsrc == 3'b011);

   assign lu     = idex_memrd && ex_match;
   assign br_ex  = is_cmp && idex_regwr && ex_match;
   assign br_mem = is_cmp && exmem_memrd && mem_match;
   assign hz     = lu || br_ex || br_mem;

   assign freeze   = (state == MEM_WAIT) || (dmem_req && !dmem_ready);
   assign redirect = (ifid_pcsrc == 3'b010) || (ifid_pcsrc == 3'b011) ||
                     ((ifid_pcsrc == 3'b001) && branch_taken);

   // Priority: reset > memory freeze > hazard stall > flush; a stall never flushes.
   always_comb begin
      pc_wr       = 1'b0;
      ifid_wr     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_hold   = 1'b0;
      if (reset) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (freeze) begin
         pipe_hold = 1'b1;
      end else if (hz) begin
         idex_bubble = 1'b1;
      end else begin
         pc_wr      = 1'b1;
         ifid_wr    = 1'b1;
         ifid_flush = redirect;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         wait_cnt  <= '0;
         stall_cnt <= '0;
         mem_err   <= 1'b0;
      end else begin
         if (!pc_wr && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
         case (state)
            RUN: begin
               if (dmem_req && !dmem_ready) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= WC_W'(1);
               end
            end
            MEM_WAIT: begin
               if (dmem_ready) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt >= WC_W'(MEM_TIMEOUT)) begin
                  // Stay frozen and hold the count; the error stays up until reset.
                  mem_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each driven cycle pushes its expected outputs,
// which are popped and compared at the following falling edge.
module tb_hazard_ctrl;

   localparam int CNT_W = 3;
   localparam logic [CNT_W-1:0] SAT = 3'd7;

   // Output vector order: {pc_wr, ifid_wr, ifid_flush, idex_bubble, pipe_hold}
   localparam logic [4:0] RUNO  = 5'b11000;
   localparam logic [4:0] FLUSH = 5'b11100;
   localparam logic [4:0] STALL = 5'b00010;
   localparam logic [4:0] FRZ   = 5'b00001;
   localparam logic [4:0] RST   = 5'b00110;

   logic             clk, reset;
   logic [4:0]       ifid_rs, ifid_rt, idex_rd, exmem_rd;
   logic             ifid_uses_rt, branch_taken;
   logic [2:0]       ifid_pcsrc;
   logic             idex_regwr, idex_memrd, exmem_regwr, exmem_memrd;
   logic             dmem_req, dmem_ready;
   logic             pc_wr, ifid_wr, ifid_flush, idex_bubble, pipe_hold, mem_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [4:0]       outs;

   typedef struct {
      logic [4:0]       outs;
      logic [CNT_W-1:0] stall;
      logic             err;
   } exp_t;

   exp_t             exp_q[$];
   logic [CNT_W-1:0] model_stall;
   bit               drv_done;
   int               checks, fails;

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
      .ifid_pcsrc(ifid_pcsrc), .branch_taken(branch_taken),
      .idex_rd(idex_rd), .idex_regwr(idex_regwr), .idex_memrd(idex_memrd),
      .exmem_rd(exmem_rd), .exmem_regwr(exmem_regwr), .exmem_memrd(exmem_memrd),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_wr(pc_wr), .ifid_wr(ifid_wr), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
      .stall_cnt(stall_cnt), .mem_err(mem_err)
   );

   assign outs = {pc_wr, ifid_wr, ifid_flush, idex_bubble, pipe_hold};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one cycle and push what the controller must produce for it. The expected stall
   // count is the value visible during this cycle, i.e. accumulated over earlier cycles.
   task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic [2:0] pcs, input logic tkn,
                        input logic [4:0] erd, input logic ewr, input logic emr,
                        input logic [4:0] mrd, input logic mwr, input logic mmr,
                        input logic req, input logic rdy,
                        input logic [4:0] eo, input logic ee);
      exp_t e;
      @(posedge clk); #1;
      reset = rst; ifid_rs = rs; ifid_rt = rt; ifid_uses_rt = urt;
      ifid_pcsrc = pcs; branch_taken = tkn;
      idex_rd = erd; idex_regwr = ewr; idex_memrd = emr;
      exmem_rd = mrd; exmem_regwr = mwr; exmem_memrd = mmr;
      dmem_req = req; dmem_ready = rdy;
      e.outs = eo; e.stall = model_stall; e.err = ee;
      exp_q.push_back(e);
      if (rst) model_stall = '0;
      else if (!eo[4] && model_stall != SAT) model_stall = model_stall + 1'b1;
   endtask

   task automatic test_reset();
      exp_t e;
      drv_done = 0;
      fork
         begin
            drive(1, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 0,0, RST,  0);
            drive(0, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 0,0, RUNO, 0);
            drv_done = 1;
         end
         for (int i = 0; ; i++) begin
            wait (exp_q.size() > 0 || drv_done);
            if (exp_q.size() == 0) break;
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (outs !== e.outs) begin fails++; $display("FAIL reset[%0d] outs got %b want %b", i, outs, e.outs); end
            checks++; if (stall_cnt !== e.stall) begin fails++; $display("FAIL reset[%0d] stall_cnt got %0d want %0d", i, stall_cnt, e.stall); end
            checks++; if (mem_err !== e.err) begin fails++; $display("FAIL reset[%0d] mem_err got %b want %b", i, mem_err, e.err); end
         end
      join
   endtask

   task automatic test_load_use();
      exp_t e;
      drv_done = 0;
      fork
         begin
            drive(1, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 0,0, RST,   0);
            drive(0, 5,6,1,3'b000,0, 5,1,1, 0,0,0, 0,0, STALL, 0);  // lw $5 in EX, add uses $5
            drive(0, 5,6,1,3'b000,0, 0,0,0, 5,1,1, 0,0, RUNO,  0);  // load moved on: forwardable
            drive(0, 3,5,1,3'b000,0, 5,1,1, 0,0,0, 0,0, STALL, 0);  // match through rt
            drive(0, 3,5,0,3'b000,0, 5,1,1, 0,0,0, 0,0, RUNO,  0);  // rt not read
            drive(0, 0,0,0,3'b000,0, 0,1,1, 0,0,0, 0,0, RUNO,  0);  // register 0 never matches
            drive(0, 5,0,0,3'b000,0, 5,1,0, 0,0,0, 0,0, RUNO,  0);  // ALU producer, not a compare
            drive(0, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 0,0, RUNO,  0);
            drv_done = 1;
         end
         for (int i = 0; ; i++) begin
            wait (exp_q.size() > 0 || drv_done);
            if (exp_q.size() == 0) break;
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (outs !== e.outs) begin fails++; $display("FAIL load_use[%0d] outs got %b want %b", i, outs, e.outs); end
            checks++; if (stall_cnt !== e.stall) begin fails++; $display("FAIL load_use[%0d] stall_cnt got %0d want %0d", i, stall_cnt, e.stall); end
            checks++; if (mem_err !== e.err) begin fails++; $display("FAIL load_use[%0d] mem_err got %b want %b", i, mem_err, e.err); end
         end
      join
   endtask

   task automatic test_branch();
      exp_t e;
      drv_done = 0;
      fork
         begin
            drive(1, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 0,0, RST,   0);
            drive(0, 7,0,1,3'b001,1, 7,1,1, 0,0,0, 0,0, STALL, 0);  // lw $7 then beq $7
            drive(0, 7,0,1,3'b001,1, 0,0,0, 7,1,1, 0,0, STALL, 0);  // load data in MEM
            drive(0, 7,0,1,3'b001,1, 0,0,0, 0,0,0, 0,0, FLUSH, 0);  // resolves, taken
            drive(0, 9,0,1,3'b001,0, 9,1,0, 0,0,0, 0,0, STALL, 0);  // ALU producer in EX
            drive(0, 9,0,1,3'b001,0, 0,0,0, 9,1,0, 0,0, RUNO,  0);  // forwarded, not taken
            drive(0, 4,0,0,3'b011,0, 0,0,0, 0,0,0, 0,0, FLUSH, 0);  // jr, no hazard
            drive(0, 4,0,0,3'b010,0, 0,0,0, 4,1,1, 0,0, FLUSH, 0);  // j reads no register
            drive(0, 4,0,0,3'b011,0, 0,0,0, 4,1,1, 0,0, STALL, 0);  // jr after load in MEM
            drive(0, 4,0,0,3'b011,0, 4,1,0, 0,0,0, 0,0, STALL, 0);  // jr after ALU in EX
            drive(0, 2,4,1,3'b001,1, 0,0,0, 4,1,1, 0,0, STALL, 0);  // beq rt matches load
            drive(0, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 0,0, RUNO,  0);
            drv_done = 1;
         end
         for (int i = 0; ; i++) begin
            wait (exp_q.size() > 0 || drv_done);
            if (exp_q.size() == 0) break;
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (outs !== e.outs) begin fails++; $display("FAIL branch[%0d] outs got %b want %b", i, outs, e.outs); end
            checks++; if (stall_cnt !== e.stall) begin fails++; $display("FAIL branch[%0d] stall_cnt got %0d want %0d", i, stall_cnt, e.stall); end
            checks++; if (mem_err !== e.err) begin fails++; $display("FAIL branch[%0d] mem_err got %b want %b", i, mem_err, e.err); end
         end
      join
   endtask

   task automatic test_mem_wait();
      exp_t e;
      drv_done = 0;
      fork
         begin
            drive(1, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 0,0, RST,  0);
            drive(0, 5,0,0,3'b000,0, 5,1,1, 0,0,0, 1,0, FRZ,  0);  // freeze beats load-use
            drive(0, 5,0,0,3'b000,0, 5,1,1, 0,0,0, 1,0, FRZ,  0);
            drive(0, 5,0,0,3'b011,0, 0,0,0, 0,0,0, 1,0, FRZ,  0);  // freeze beats flush
            drive(0, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 1,1, FRZ,  0);  // completing cycle still frozen
            drive(0, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 0,0, RUNO, 0);
            drive(0, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 1,1, RUNO, 0);  // zero-wait access
            drive(0, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 0,0, RUNO, 0);
            drv_done = 1;
         end
         for (int i = 0; ; i++) begin
            wait (exp_q.size() > 0 || drv_done);
            if (exp_q.size() == 0) break;
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (outs !== e.outs) begin fails++; $display("FAIL mem_wait[%0d] outs got %b want %b", i, outs, e.outs); end
            checks++; if (stall_cnt !== e.stall) begin fails++; $display("FAIL mem_wait[%0d] stall_cnt got %0d want %0d", i, stall_cnt, e.stall); end
            checks++; if (mem_err !== e.err) begin fails++; $display("FAIL mem_wait[%0d] mem_err got %b want %b", i, mem_err, e.err); end
         end
      join
   endtask

   task automatic test_timeout();
      exp_t e;
      drv_done = 0;
      fork
         begin
            drive(1, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 0,0, RST,  0);
            drive(0, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 1,0, FRZ,  0);  // enter wait
            for (int k = 0; k < 4; k++)
               drive(0, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 1,0, FRZ, 0);  // four wait cycles
            drive(0, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 1,0, FRZ,  1);  // timeout flagged
            drive(0, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 1,1, FRZ,  1);
            drive(0, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 0,0, RUNO, 1);  // sticky after exit
            drive(0, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 1,0, FRZ,  1);
            drive(1, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 1,0, RST,  1);  // reset while waiting
            drive(0, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 0,0, RUNO, 0);
            drv_done = 1;
         end
         for (int i = 0; ; i++) begin
            wait (exp_q.size() > 0 || drv_done);
            if (exp_q.size() == 0) break;
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (outs !== e.outs) begin fails++; $display("FAIL timeout[%0d] outs got %b want %b", i, outs, e.outs); end
            checks++; if (stall_cnt !== e.stall) begin fails++; $display("FAIL timeout[%0d] stall_cnt got %0d want %0d", i, stall_cnt, e.stall); end
            checks++; if (mem_err !== e.err) begin fails++; $display("FAIL timeout[%0d] mem_err got %b want %b", i, mem_err, e.err); end
         end
      join
   endtask

   task automatic test_saturate();
      exp_t e;
      drv_done = 0;
      fork
         begin
            drive(1, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 0,0, RST, 0);
            for (int k = 0; k < 10; k++)
               drive(0, 5,0,0,3'b000,0, 5,1,1, 0,0,0, 0,0, STALL, 0);
            drive(0, 0,0,0,3'b000,0, 0,0,0, 0,0,0, 0,0, RUNO, 0);
            drv_done = 1;
         end
         for (int i = 0; ; i++) begin
            wait (exp_q.size() > 0 || drv_done);
            if (exp_q.size() == 0) break;
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (outs !== e.outs) begin fails++; $display("FAIL saturate[%0d] outs got %b want %b", i, outs, e.outs); end
            checks++; if (stall_cnt !== e.stall) begin fails++; $display("FAIL saturate[%0d] stall_cnt got %0d want %0d", i, stall_cnt, e.stall); end
            checks++; if (mem_err !== e.err) begin fails++; $display("FAIL saturate[%0d] mem_err got %b want %b", i, mem_err, e.err); end
         end
      join
   endtask

   initial begin
      checks = 0; fails = 0; model_stall = '0; drv_done = 0;
      reset = 1'b1; ifid_rs = '0; ifid_rt = '0; ifid_uses_rt = 1'b0;
      ifid_pcsrc = '0; branch_taken = 1'b0;
      idex_rd = '0; idex_regwr = 1'b0; idex_memrd = 1'b0;
      exmem_rd = '0; exmem_regwr = 1'b0; exmem_memrd = 1'b0;
      dmem_req = 1'b0; dmem_ready = 1'b0;
      repeat (2) @(posedge clk);
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It decides each cycle whether the front end advances, stalls, or is flushed. It also freezes the whole pipeline while the data memory port is busy. It sits beside the forwarding unit: it handles the hazards that forwarding cannot resolve, namely load-use, a branch or `jr` that needs a value not yet forwardable, and memory wait states. It also keeps stall and timeout statistics.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 64: maximum consecutive MEM_WAIT cycles before `mem_err` is raised.
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ifid_rs`, `ifid_rt` in 5 each: source registers of the instruction in ID.
- `ifid_uses_rt` in 1: the ID instruction reads `rt` as a register operand.
- `ifid_pcsrc` in 3: next-PC source. 000 sequential, 001 branch, 010 jump, 011 jump register.
- `branch_taken` in 1: ID compare result; meaningful only when `ifid_pcsrc`=001.
- `idex_rd` in 5, `idex_regwr` in 1, `idex_memrd` in 1: destination, register write and load flag of the EX instruction.
- `exmem_rd` in 5, `exmem_regwr` in 1, `exmem_memrd` in 1: the same fields for the MEM instruction.
- `dmem_req` in 1, `dmem_ready` in 1: the MEM-stage access is active / completes this cycle.
- `pc_wr` out 1: PC load enable.
- `ifid_wr` out 1: IF/ID register enable.
- `ifid_flush` out 1: replace IF/ID with a NOP.
- `idex_bubble` out 1: load a NOP into ID/EX.
- `pipe_hold` out 1: hold ID/EX, EX/MEM and MEM/WB.
- `stall_cnt` out `CNT_W`: saturating count of stalled cycles.
- `mem_err` out 1: sticky memory timeout flag.

## Operation
Match definitions (register 0 never matches):
- `m_id(r)`: r equals `ifid_rs`, or (`ifid_uses_rt` and r equals `ifid_rt`).
- `is_cmp`: `ifid_pcsrc` is 001 or 011.

Hazard conditions, evaluated only in RUN:
- LU (load-use): `idex_memrd` and `m_id(idex_rd)`.
- BR_EX: `is_cmp`, `idex_regwr`, `m_id(idex_rd)`. The ALU result is not yet in EX/MEM.
- BR_MEM: `is_cmp`, `exmem_memrd`, `m_id(exmem_rd)`. The compare path forwards only EX/MEM ALU data, not load data.
- `hz` = LU or BR_EX or BR_MEM.

State machine (states RUN, MEM_WAIT):
- RUN, `dmem_req` and not `dmem_ready`:
  - `pipe_hold`=1, `pc_wr`=0, `ifid_wr`=0, `idex_bubble`=0, `ifid_flush`=0.
  - Next state MEM_WAIT; the wait counter loads 1.
- RUN, otherwise, `hz`=1:
  - `pc_wr`=0, `ifid_wr`=0, `idex_bubble`=1, `ifid_flush`=0.
- RUN, otherwise, no hazard:
  - `pc_wr`=1, `ifid_wr`=1.
  - `ifid_flush`=1 when `ifid_pcsrc` is 010 or 011, or is 001 with `branch_taken`.
- MEM_WAIT:
  - Same outputs as the RUN memory-freeze case.
  - Wait counter increments.
  - On `dmem_ready`: outputs still frozen that cycle, next state RUN, wait counter cleared.
  - When the wait counter reaches `MEM_TIMEOUT`: `mem_err` is set (sticky until reset) and the FSM stays in MEM_WAIT.
- Load followed by a dependent branch: BR_EX stalls in cycle 1, BR_MEM stalls in cycle 2. The result is exactly 2 bubbles from re-evaluation; no extra state.
- `stall_cnt` increments on every cycle with `pc_wr`=0 outside reset, and saturates at all-ones.

## Timing
- All control outputs are combinational (Mealy) from the state and the current inputs; they take effect at the next edge. `stall_cnt` and `mem_err` are registered.
- During reset:
  - `pc_wr`=0, `ifid_wr`=0, `ifid_flush`=1, `idex_bubble`=1, `pipe_hold`=0.
  - Next state RUN; the wait counter, `stall_cnt` and `mem_err` clear to 0.
- Reset asserted in MEM_WAIT returns to RUN on the next edge without waiting for `dmem_ready`.
- Priority: reset > memory freeze > `hz` > flush. A flush is never asserted in the same cycle as a stall. A branch stalled by `hz` resolves on a later cycle.
- Latency costs:
  - LU: 1 bubble.
  - BR_EX on an ALU producer: 1 bubble.
  - Load then dependent branch: 2 bubbles.
  - Taken branch or jump: 1 flushed slot.
  - Memory wait of N cycles: N frozen cycles plus the completing cycle.

## Test plan
- `lw $5` in EX (`idex_memrd`=1, `idex_rd`=5), `add` in ID with `ifid_rs`=5 -> one cycle of `pc_wr`=0, `idex_bubble`=1; next cycle `pc_wr`=1; `stall_cnt`=1.
- `lw $7` then `beq $7,$0` (`ifid_pcsrc`=001) -> two consecutive bubbles (BR_EX, then BR_MEM); the third cycle `pc_wr`=1 and, with `branch_taken`=1, `ifid_flush`=1.
- `idex_rd`=0 with `idex_memrd`=1 and `ifid_rs`=0 -> no stall; `pc_wr`=1.
- `dmem_req`=1 with `dmem_ready` low for 3 cycles -> `pipe_hold`=1 for 4 cycles, simultaneous `hz` ignored, return to RUN; `stall_cnt`=4.
- `MEM_TIMEOUT`=4, `dmem_ready` held low -> `mem_err` rises after 4 wait cycles and stays high; asserting `reset` clears it and returns to RUN.
- `jr` with no hazard -> `ifid_flush`=1 and `pc_wr`=1 in the same cycle; `beq` with `branch_taken`=0 -> `ifid_flush`=0.
